vending_machine_gen: RTL and testbench
======================================

VENDING_MACHINE_GEN -- requirements
Module: vending_machine_gen

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 Parameter ITEM_W, default 2, SHALL set the item index width; the item count is 2**ITEM_W.
REQ-003 Parameter CREDIT_W, default 6, SHALL set the width of credit, price and change, all counted in units of 10 dollars.
REQ-004 Parameter BASE_PRICE, default 2, SHALL set the price of item 0 in units.
REQ-005 Parameter PRICE_STEP, default 1, SHALL set the price increment per item index, so price(i) = BASE_PRICE + i*PRICE_STEP.
REQ-006 Parameter STOCK_INIT, default 3, SHALL set the per-item stock loaded at reset (used only with STOCK_COUNT_EN).
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 sel  in  1  one-cycle select strobe.
REQ-010 item  in  ITEM_W  item index, sampled when sel=1.
REQ-011 coin_10 / coin_50 / coin_100  in  1 each  one-cycle coin pulses, worth 1 / 5 / 10 units.
REQ-012 cancel  in  1  one-cycle refund request.
REQ-013 price  out  CREDIT_W  price of the latched item.
REQ-014 credit  out  CREDIT_W  credit accumulated so far.
REQ-015 item_rels  out  ITEM_W+1  release bus: {valid, item}.
REQ-016 change_10  out  1  one pulse per 10-dollar coin returned.
REQ-017 coin_reject  out  1  one-cycle pulse when an inserted coin is not accepted.
REQ-018 sold_out  out  1  one-cycle pulse when a selected item is out of stock.
REQ-019 busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, PAY, VEND and CHG; all outputs SHALL be registered.
REQ-021 In IDLE, sel SHALL latch item, load price(item), clear credit and enter PAY on the next edge.
REQ-022 In IDLE, coins SHALL be rejected (coin_reject=1) and cancel SHALL be ignored.
REQ-023 In PAY, the values of all coin pulses in a cycle SHALL be summed and added to credit in that cycle.
REQ-024 If credit+sum would exceed 2**CREDIT_W-1, the whole cycle's coins SHALL be rejected and credit left unchanged.
REQ-025 In PAY, the block SHALL enter VEND on the same edge on which the updated credit becomes >= price.
REQ-026 In PAY, sel SHALL re-latch the item and price and keep credit; the VEND check SHALL use the new price.
REQ-027 In PAY, cancel SHALL take priority over coins and sel in the same cycle: change=credit, credit=0, enter CHG (or IDLE if credit=0), with no release.
REQ-028 VEND SHALL last exactly one cycle: item_rels={1,item}, change=credit-price, credit=0; next state is CHG if change>0, else IDLE.
REQ-029 In CHG, change_10 SHALL pulse on each cycle, decrementing change by 1, and the block SHALL return to IDLE on the edge on which change reaches 0.
REQ-030 In VEND and CHG, coins SHALL be rejected and sel and cancel ignored.
REQ-031 item_rels SHALL be 0 in every cycle except VEND; price SHALL be 0 in IDLE.

Reset
REQ-032 When reset_n=0, the block SHALL immediately, independent of clk, force: state IDLE; price, credit, change and item_rels = 0; change_10, coin_reject, sold_out and busy = 0.
REQ-033 Reset asserted mid-PAY or mid-CHG SHALL discard the credit or change without any release or refund pulses.
REQ-034 Deassertion of reset SHALL be the only way stock counters reload.

Configuration
REQ-035 With macro STOCK_COUNT_EN defined, the block SHALL keep a per-item stock counter, loaded with STOCK_INIT at reset and decremented in VEND.
REQ-036 With STOCK_COUNT_EN defined, sel of an item with stock 0 SHALL pulse sold_out and leave state, item and price unchanged (IDLE or PAY).
REQ-037 With STOCK_COUNT_EN defined, stock SHALL saturate at 0.
REQ-038 Without STOCK_COUNT_EN, no stock counters SHALL exist, stock SHALL be unlimited, and sold_out SHALL be tied to 0.

Verification
REQ-039 Exact pay, defaults: sel item=1 (price 3), then three coin_10 pulses -> one VEND cycle with item_rels=3'b101, zero change_10 pulses, return to IDLE.
REQ-040 Overpay: sel item=0 (price 2), then coin_50 -> item_rels=3'b100, then 3 consecutive change_10 pulses, then IDLE.
REQ-041 Cancel and reselect: sel item=3, coin_10, sel item=1, coin_10, cancel -> no release, 2 change_10 pulses, credit=0.
REQ-042 Overflow and simultaneous coins: credit=60, coin_50 and coin_10 in the same cycle -> coin_reject=1, credit stays 60; coin_10 and coin_50 together with price 5 -> credit=6, VEND, 1 change_10 pulse.
REQ-043 Reset and stock: reset_n low mid-CHG -> all outputs 0 asynchronously; with STOCK_COUNT_EN, a fourth purchase of item 2 -> sold_out pulse and state remains IDLE.

Source files
------------

// File: rtl/vending_machine_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vending_machine_gen                                                         |
// | Parameterised vending FSM (IDLE/PAY/VEND/CHG) with registered outputs.     |
// | Optional macro STOCK_COUNT_EN adds per-item stock counters and sold_out.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vending_machine_gen #(
    parameter int ITEM_W     = 2,
    parameter int CREDIT_W   = 6,
    parameter int BASE_PRICE = 2,
    parameter int PRICE_STEP = 1,
    parameter int STOCK_INIT = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sel,
    input  logic [ITEM_W-1:0]   item,
    input  logic                coin_10,
    input  logic                coin_50,
    input  logic                coin_100,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] price,
    output logic [CREDIT_W-1:0] credit,
    output logic [ITEM_W:0]     item_rels,
    output logic                change_10,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                busy
);

    localparam int C_N_ITEMS = 2 ** ITEM_W;
    localparam int SUM_W     = CREDIT_W + 5;
    localparam logic [SUM_W-1:0]    C_MAX_CREDIT = SUM_W'((2 ** CREDIT_W) - 1);
    localparam logic [CREDIT_W-1:0] C_ONE        = CREDIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PAY  = 2'd1,
        S_VEND = 2'd2,
        S_CHG  = 2'd3
    } state_t;

    state_t              r_state, w_state_nx;
    logic [ITEM_W-1:0]   r_item, w_item_nx;
    logic [CREDIT_W-1:0] r_change, w_change_nx;
    logic [CREDIT_W-1:0] w_price_nx, w_credit_nx, w_sel_price;
    logic [ITEM_W:0]     w_rels_nx;
    logic                w_chg10_nx, w_reject_nx, w_soldout_nx;
    logic [SUM_W-1:0]    w_coin_sum, w_credit_sum;
    logic                w_any_coin, w_in_stock;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
        int p;
        p = BASE_PRICE + int'(idx) * PRICE_STEP;
        return p[CREDIT_W-1:0];
    endfunction

`ifdef STOCK_COUNT_EN
    localparam int STOCK_W = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);
    logic [STOCK_W-1:0] r_stock [C_N_ITEMS];

    // Counters reload only through reset; VEND consumes one unit, saturating at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < C_N_ITEMS; i++) begin
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else if (r_state == S_VEND && r_stock[r_item] != '0) begin
            r_stock[r_item] <= r_stock[r_item] - STOCK_W'(1);
        end
    end

    assign w_in_stock = (r_stock[item] != '0);
`else
    // Unlimited stock; STOCK_INIT only matters when counters are built.
    assign w_in_stock = 1'b1 | (STOCK_INIT != 0);
`endif

    assign w_any_coin   = coin_10 | coin_50 | coin_100;
    assign w_coin_sum   = (coin_10  ? SUM_W'(1)  : '0)
                        + (coin_50  ? SUM_W'(5)  : '0)
                        + (coin_100 ? SUM_W'(10) : '0);
    assign w_credit_sum = SUM_W'(credit) + w_coin_sum;
    assign w_sel_price  = price_of(item);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_item      <= '0;
            r_change    <= '0;
            price       <= '0;
            credit      <= '0;
            item_rels   <= '0;
            change_10   <= 1'b0;
            coin_reject <= 1'b0;
            sold_out    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_item      <= w_item_nx;
            r_change    <= w_change_nx;
            price       <= w_price_nx;
            credit      <= w_credit_nx;
            item_rels   <= w_rels_nx;
            change_10   <= w_chg10_nx;
            coin_reject <= w_reject_nx;
            sold_out    <= w_soldout_nx;
            busy        <= (w_state_nx != S_IDLE);
        end
    end

    // Entering CHG already emits the first change pulse, so r_change holds the pulses still owed.
    always_comb begin
        w_state_nx   = r_state;
        w_item_nx    = r_item;
        w_change_nx  = r_change;
        w_price_nx   = price;
        w_credit_nx  = credit;
        w_rels_nx    = '0;
        w_chg10_nx   = 1'b0;
        w_reject_nx  = 1'b0;
        w_soldout_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_reject_nx = w_any_coin;
                w_price_nx  = '0;
                w_credit_nx = '0;
                if (sel) begin
                    if (w_in_stock) begin
                        w_item_nx  = item;
                        w_price_nx = w_sel_price;
                        w_state_nx = S_PAY;
                    end else begin
                        w_soldout_nx = 1'b1;
                    end
                end
            end
            S_PAY: begin
                if (cancel) begin
                    w_reject_nx = w_any_coin;
                    w_credit_nx = '0;
                    if (credit != '0) begin
                        w_state_nx  = S_CHG;
                        w_chg10_nx  = 1'b1;
                        w_change_nx = credit - C_ONE;
                    end else begin
                        w_state_nx  = S_IDLE;
                        w_change_nx = '0;
                        w_price_nx  = '0;
                    end
                end else begin
                    if (sel) begin
                        if (w_in_stock) begin
                            w_item_nx  = item;
                            w_price_nx = w_sel_price;
                        end else begin
                            w_soldout_nx = 1'b1;
                        end
                    end
                    if (w_credit_sum > C_MAX_CREDIT) begin
                        w_reject_nx = 1'b1;
                    end else begin
                        w_credit_nx = w_credit_sum[CREDIT_W-1:0];
                    end
                    if (w_credit_nx >= w_price_nx) begin
                        w_state_nx = S_VEND;
                        w_rels_nx  = {1'b1, w_item_nx};
                    end
                end
            end
            S_VEND: begin
                w_reject_nx = w_any_coin;
                w_credit_nx = '0;
                if (credit > price) begin
                    w_state_nx  = S_CHG;
                    w_chg10_nx  = 1'b1;
                    w_change_nx = credit - price - C_ONE;
                end else begin
                    w_state_nx  = S_IDLE;
                    w_change_nx = '0;
                    w_price_nx  = '0;
                end
            end
            S_CHG: begin
                w_reject_nx = w_any_coin;
                if (r_change != '0) begin
                    w_chg10_nx  = 1'b1;
                    w_change_nx = r_change - C_ONE;
                end else begin
                    w_state_nx = S_IDLE;
                    w_price_nx = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vending_machine_gen                                                      |
// | Directed scoreboard bench for vending_machine_gen.                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vending_machine_gen;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic       sel      = 1'b0;
    logic [1:0] item     = 2'd0;
    logic       coin_10  = 1'b0;
    logic       coin_50  = 1'b0;
    logic       coin_100 = 1'b0;
    logic       cancel   = 1'b0;
    logic [5:0] price, credit;
    logic [2:0] item_rels;
    logic       change_10, coin_reject, sold_out, busy;

    // Second instance with a high base price so credit can climb near the ceiling.
    logic       b_sel      = 1'b0;
    logic [1:0] b_item     = 2'd0;
    logic       b_coin_10  = 1'b0;
    logic       b_coin_50  = 1'b0;
    logic       b_coin_100 = 1'b0;
    logic       b_cancel   = 1'b0;
    logic [5:0] b_price, b_credit;
    logic [2:0] b_item_rels;
    logic       b_change_10, b_coin_reject, b_sold_out, b_busy;

    vending_machine_gen u_dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .item(item),
        .coin_10(coin_10), .coin_50(coin_50), .coin_100(coin_100), .cancel(cancel),
        .price(price), .credit(credit), .item_rels(item_rels), .change_10(change_10),
        .coin_reject(coin_reject), .sold_out(sold_out), .busy(busy)
    );

    vending_machine_gen #(.BASE_PRICE(61)) u_ovf (
        .clk(clk), .reset_n(reset_n), .sel(b_sel), .item(b_item),
        .coin_10(b_coin_10), .coin_50(b_coin_50), .coin_100(b_coin_100), .cancel(b_cancel),
        .price(b_price), .credit(b_credit), .item_rels(b_item_rels), .change_10(b_change_10),
        .coin_reject(b_coin_reject), .sold_out(b_sold_out), .busy(b_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] rels;
        int         pulses;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sel(input logic [1:0] it);
        sel  = 1'b1;
        item = it;
        tick();
        sel  = 1'b0;
    endtask

    task automatic do_coin(input logic c10, input logic c50, input logic c100);
        coin_10  = c10;
        coin_50  = c50;
        coin_100 = c100;
        tick();
        coin_10  = 1'b0;
        coin_50  = 1'b0;
        coin_100 = 1'b0;
    endtask

    // Follow one transaction to IDLE, then pop and compare its expected outcome.
    task automatic check_txn(input string tag);
        logic [2:0] rels_seen;
        int         pulses;
        bit         done;
        exp_t       e;
        rels_seen = '0;
        pulses    = 0;
        done      = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (item_rels[2]) rels_seen = item_rels;
            if (change_10) pulses++;
            if (!busy) done = 1'b1;
            else tick();
        end
        chk({tag, "_idle"}, 32'(done), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rels"}, 32'(rels_seen), 32'(e.rels));
            chk({tag, "_change"}, 32'(pulses), 32'(e.pulses));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_price"}, 32'(price), 32'd0);
        chk({tag, "_credit"}, 32'(credit), 32'd0);
        chk({tag, "_rels"}, 32'(item_rels), 32'd0);
        chk({tag, "_chg10"}, 32'(change_10), 32'd0);
        chk({tag, "_reject"}, 32'(coin_reject), 32'd0);
        chk({tag, "_soldout"}, 32'(sold_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        #1 chk_all_zero("reset");
        #5 reset_n = 1'b1;
        tick();

        // Coins in IDLE are rejected for one cycle
        do_coin(1'b1, 1'b0, 1'b0);
        chk("idle_reject", 32'(coin_reject), 32'd1);
        chk("idle_credit", 32'(credit), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        chk("idle_reject_end", 32'(coin_reject), 32'd0);

        // Exact pay: item 1 price 3
        do_sel(2'd1);
        chk("exact_price", 32'(price), 32'd3);
        chk("exact_busy", 32'(busy), 32'd1);
        sb.push_back('{3'b101, 0});
        do_coin(1'b1, 1'b0, 1'b0);
        do_coin(1'b1, 1'b0, 1'b0);
        chk("exact_credit2", 32'(credit), 32'd2);
        do_coin(1'b1, 1'b0, 1'b0);
        check_txn("exact");
        chk("exact_price_idle", 32'(price), 32'd0);
        chk("exact_credit_idle", 32'(credit), 32'd0);

        // Overpay: item 0 price 2, coin_50 leaves 3 units of change
        do_sel(2'd0);
        sb.push_back('{3'b100, 3});
        do_coin(1'b0, 1'b1, 1'b0);
        check_txn("overpay");

        // Cancel after reselect refunds accumulated credit
        do_sel(2'd3);
        chk("cancel_price5", 32'(price), 32'd5);
        do_coin(1'b1, 1'b0, 1'b0);
        do_sel(2'd1);
        chk("cancel_price3", 32'(price), 32'd3);
        chk("cancel_credit1", 32'(credit), 32'd1);
        do_coin(1'b1, 1'b0, 1'b0);
        sb.push_back('{3'b000, 2});
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_txn("cancel");
        chk("cancel_credit0", 32'(credit), 32'd0);

        // Simultaneous coins summed in one cycle
        do_sel(2'd3);
        sb.push_back('{3'b111, 1});
        do_coin(1'b1, 1'b1, 1'b0);
        chk("simul_credit", 32'(credit), 32'd6);
        check_txn("simul");

        // Overflow on the high-price instance
        b_sel = 1'b1;
        b_item = 2'd0;
        tick();
        b_sel = 1'b0;
        chk("ovf_price", 32'(b_price), 32'd61);
        for (int i = 0; i < 6; i++) begin
            b_coin_100 = 1'b1;
            tick();
            b_coin_100 = 1'b0;
        end
        chk("ovf_credit60", 32'(b_credit), 32'd60);
        b_coin_50 = 1'b1;
        b_coin_10 = 1'b1;
        tick();
        b_coin_50 = 1'b0;
        b_coin_10 = 1'b0;
        chk("ovf_reject", 32'(b_coin_reject), 32'd1);
        chk("ovf_credit_kept", 32'(b_credit), 32'd60);
        chk("ovf_busy", 32'(b_busy), 32'd1);
        b_coin_10 = 1'b1;
        tick();
        b_coin_10 = 1'b0;
        chk("ovf_rels", 32'(b_item_rels), 32'h4);
        chk("ovf_credit61", 32'(b_credit), 32'd61);
        tick();
        chk("ovf_idle", 32'(b_busy), 32'd0);
        chk("ovf_no_change", 32'(b_change_10), 32'd0);

        // Reset asserted mid-CHG clears everything without waiting for a clock
        do_sel(2'd0);
        do_coin(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("midchg_pulse", 32'(change_10), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        #2 reset_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_chg10", 32'(change_10), 32'd0);

        // Three purchases of item 2 (price 4), then a fourth select
        for (int n = 0; n < 3; n++) begin
            do_sel(2'd2);
            sb.push_back('{3'b110, 0});
            for (int k = 0; k < 4; k++) do_coin(1'b1, 1'b0, 1'b0);
            check_txn("stock_buy");
        end
        do_sel(2'd2);
`ifdef STOCK_COUNT_EN
        chk("soldout_pulse", 32'(sold_out), 32'd1);
        chk("soldout_busy", 32'(busy), 32'd0);
        chk("soldout_price", 32'(price), 32'd0);
        tick();
        chk("soldout_end", 32'(sold_out), 32'd0);
`else
        chk("unlimited_soldout", 32'(sold_out), 32'd0);
        chk("unlimited_busy", 32'(busy), 32'd1);
        chk("unlimited_price", 32'(price), 32'd4);
        sb.push_back('{3'b110, 0});
        for (int k = 0; k < 4; k++) do_coin(1'b1, 1'b0, 1'b0);
        check_txn("unlimited_buy");
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
